// File: rtl/ms_jk_flip_flop_pkg.sv
// Shared JK command encoding and the next-state rule used by every cell.
package ms_jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  function automatic logic jk_next(jk_cmd_e cmd, logic q);
    logic nxt;
    case (cmd)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ms_jk_flip_flop_if.sv
// JK bank data bus: J/K commands in, Q/Qn state out.
interface ms_jk_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;

    modport master (output J, output K, input Q, input Qn);
    modport slave  (input J, input K, output Q, output Qn);
endinterface

// File: rtl/ms_jk_flip_flop_cell.sv
// One master-slave JK bit: master captures on rise, slave follows on fall.
module ms_jk_cell
    import ms_jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic qn_o
);
    logic m_q, m_d;
    logic q_q, q_d;

    // Next state depends on the slave value, so toggling never races around.
    always_comb begin
        m_d = 1'b0;
        if (rst_n) m_d = jk_next(jk_cmd_e'({j_i, k_i}), q_q);
    end

    always_ff @(posedge clk) m_q <= m_d;

    always_comb begin
        q_d = 1'b0;
        if (rst_n) q_d = m_q;
    end

    always_ff @(negedge clk) q_q <= q_d;

    assign q_o  = q_q;
    assign qn_o = ~q_q;
endmodule

// File: rtl/ms_jk_flip_flop.sv
// Bank of WIDTH independent master-slave JK flip-flops.
module ms_jk_flip_flop
    import ms_jk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ms_jk_flip_flop_if.slave        bus
);
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ms_jk_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .j_i  (bus.J[i]),
            .k_i  (bus.K[i]),
            .q_o  (q_w[i]),
            .qn_o (qn_w[i])
        );
    end

    assign bus.Q  = q_w;
    assign bus.Qn = qn_w;
endmodule

// File: tb/tb_ms_jk_flip_flop.sv
// Randomized and directed checks of the JK bank against a truth-table model.
module tb_ms_jk_flip_flop;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ms_jk_flip_flop_if #(.WIDTH(W)) bus ();

    ms_jk_flip_flop #(.WIDTH(W)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_m = '0;
    bit known = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    // JK truth table applied bit by bit.
    function automatic logic [W-1:0] model_next(logic [W-1:0] j, logic [W-1:0] k, logic [W-1:0] q);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case ({j[i], k[i]})
                2'b00:   r[i] = q[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                default: r[i] = ~q[i];
            endcase
        end
        return r;
    endfunction

    // Entered just after a falling edge; leaves just after the next one.
    task automatic step(input logic [W-1:0] j, input logic [W-1:0] k, input logic rn, input bit pulse);
        if (pulse) begin
            bus.J = '1;
            bus.K = '0;
            #2;
        end
        bus.J = j;
        bus.K = k;
        rst_n = rn;
        @(posedge clk);
        #1;
        if (known) chk("high_q", bus.Q, exp_q);
        exp_m = rn ? model_next(j, k, exp_q) : '0;
        bus.J = W'($urandom);
        bus.K = W'($urandom);
        #2;
        if (known) chk("high_q_noise", bus.Q, exp_q);
        @(negedge clk);
        #1;
        exp_q = rn ? exp_m : '0;
        known = 1'b1;
        chk("q", bus.Q, exp_q);
        chk("qn", bus.Qn, ~exp_q);
    endtask

    initial begin
        bus.J = '0;
        bus.K = '0;
        @(negedge clk);
        #1;
        // Reset with toggle requested, then release into hold.
        step('1, '1, 1'b0, 1'b0);
        step('1, '1, 1'b0, 1'b0);
        chk("reset_q0", bus.Q, 4'b0000);
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        chk("release_hold", bus.Q, 4'b0000);
        // set, hold, reset, hold
        step('1, '0, 1'b1, 1'b0);
        chk("set_q1", bus.Q, 4'b1111);
        step('0, '0, 1'b1, 1'b0);
        step('0, '1, 1'b1, 1'b0);
        chk("reset_qn1", bus.Qn, 4'b1111);
        step('0, '0, 1'b1, 1'b0);
        // toggle four times
        for (int t = 0; t < 4; t++) begin
            step('1, '1, 1'b1, 1'b0);
            chk("toggle", bus.Q, (t % 2 == 0) ? 4'b1111 : 4'b0000);
        end
        // mixed 01,10,11,00
        step('0, '1, 1'b1, 1'b0);
        step('1, '0, 1'b1, 1'b0);
        step('1, '1, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        chk("mixed_end", bus.Q, 4'b0000);
        // J pulse confined to low phase must be ignored
        step('0, '0, 1'b1, 1'b1);
        chk("pulse_ignored", bus.Q, 4'b0000);
        // per-bit commands {01,10,11,00} from reset
        step('0, '0, 1'b0, 1'b0);
        step(4'b0110, 4'b1010, 1'b1, 1'b0);
        chk("perbit_q", bus.Q, 4'b0110);
        chk("perbit_qn", bus.Qn, 4'b1001);
        // random traffic with occasional mid-run reset
        for (int n = 0; n < 300; n++) begin
            step(W'($urandom), W'($urandom), ($urandom_range(0, 19) != 0), bit'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ms_jk_flip_flop.md
# ms_jk_flip_flop

Master-slave JK flip-flop bank: WIDTH independent JK bits. Each bit's master stage samples J/K on the rising clock edge, and its slave stage transfers the master to Q/Qn on the following falling edge. Used wherever edge-isolated JK hold/set/reset/toggle storage is needed; outputs change only on falling edges, so downstream logic clocked on the rising edge sees stable values.

## Interface
- WIDTH, 1: number of independent JK bits; must be 1 or greater.
- clk  input  1  clock; master acts on the rising edge, slave on the falling edge.
- rst_n  input  1  synchronous, active-low reset; sampled on clock edges only.
- J  input  WIDTH  per-bit J (set) input.
- K  input  WIDTH  per-bit K (reset) input.
- Q  output  WIDTH  per-bit stored state, driven directly from the slave register.
- Qn  output  WIDTH  per-bit complement of Q.

## Operation
- Per-bit command {J,K}:
  - 00 hold: next = Q.
  - 01 reset: next = 0.
  - 10 set: next = 1.
  - 11 toggle: next = ~Q.
- Equivalent: next = (J & ~Q) | (~K & Q), bitwise.
- Master stage, rising edge of clk:
  - rst_n = 0: M <= 0.
  - Otherwise: M <= next, computed from J, K and the current slave Q.
- Slave stage, falling edge of clk:
  - rst_n = 0: Q <= 0.
  - Otherwise: Q <= M.
- Qn = ~Q at all times. Q and Qn are never equal once out of reset.
- Bits are fully independent; no cross-bit interaction.
- Asynchronous clear paths, latches and combinational paths from J/K to Q are not permitted.
- J/K changes between edges have no effect. Only the value present at the rising edge matters; there is no ones-catching.

## Timing
- Latency: J/K sampled at rising edge n appear on Q at the falling edge of cycle n, half a period later.
- Q is stable from one falling edge to the next, across the entire high phase.
- Toggle (11) held for N cycles: Q flips exactly once per cycle, N flips total. There is no race-around.
- Reset, rst_n low across one full cycle:
  - M = 0 after the rising edge.
  - Q = 0, Qn = 1 after the following falling edge.
- Before the first reset, the values of Q and Qn are undefined.
- Reset mid-operation:
  - rst_n low at a rising edge discards that edge's J/K. M is cleared.
  - rst_n low at a falling edge clears Q regardless of M.
- Deassertion:
  - The first rising edge with rst_n = 1 computes next from Q = 0.
  - Q reflects that value at the following falling edge.
- rst_n is asserted and deasserted synchronously to clk and must meet setup to both edges.

## Structure
- Shared package ms_jk_pkg:
  - typedef enum logic [1:0] jk_cmd_e: JK_HOLD = 2'b00, JK_RESET = 2'b01, JK_SET = 2'b10, JK_TOGGLE = 2'b11.
  - Function jk_next(cmd, q) returning the next state.
- Sub-module ms_jk_cell:
  - One bit: master register, slave register, complement output.
  - Top level generates WIDTH instances.

## Test plan
- Reset, then hold:
  - rst_n = 0 for 2 cycles with J = K = 1 → Q = 0, Qn = 1 throughout, no toggling.
  - Release with J = K = 0 for 2 cycles → Q remains 0.
- Set/reset/hold sequence, WIDTH = 1:
  - 10 → Q = 1 at the falling edge of the same cycle.
  - 00 → Q stays 1.
  - 01 → Q = 0, Qn = 1.
  - 00 → Q stays 0.
- Toggle: from Q = 0, apply 11 for 4 cycles → Q = 1, 0, 1, 0 at successive falling edges; exactly one change per cycle.
- Mixed sequence: 01, 10, 11, 00 → Q = 0, 1, 0, 0 at successive falling edges.
- Edge isolation:
  - Pulse J = 1 only during the low phase, between a falling and the next rising edge → Q unchanged.
  - Check Q does not change in the high phase while J/K vary → Q changes only at falling edges.
- WIDTH = 4, reset state 0000, then per-bit commands {01, 10, 11, 00} for one cycle → Q = 0110, Qn = 1001.
